regfile_bypass: RTL

- 32-entry x 64-bit LEGv8 register file for the ID stage of the pipelined CPU.
- Provides two combinational read ports (Rn, Rm) and one write port driven from MEM/WB.
- An internal write-to-read bypass returns the MEM/WB write data in the same cycle the write lands, so ID never reads a stale operand.
- X31 (XZR) always reads zero.

---
 rtl/regfile_bypass.sv | 70 +++++++
 1 files changed

// File: rtl/regfile_bypass.sv
// LEGv8 ID-stage register file: two combinational read ports, one MEM/WB write port,
// and a write-to-read bypass so a read in the write cycle sees the incoming data.
module regfile_bypass #(
  parameter int DATA_W   = 64,
  parameter int N_REGS   = 32,
  parameter int ZERO_REG = 31
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      RegWrite,
  input  logic [$clog2(N_REGS)-1:0] WriteRegister,
  input  logic [DATA_W-1:0]         WriteData,
  input  logic [$clog2(N_REGS)-1:0] ReadRegister1,
  input  logic [$clog2(N_REGS)-1:0] ReadRegister2,
  output logic [DATA_W-1:0]         ReadData1,
  output logic [DATA_W-1:0]         ReadData2,
  output logic                      bypass1,
  output logic                      bypass2
);

  localparam int AW = $clog2(N_REGS);
  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [N_REGS];
  logic [DATA_W-1:0] regs_d [N_REGS];
  logic              wr_en;

  // The XZR slot is never written, so it stays at its reset value of zero.
  assign wr_en = RegWrite && (WriteRegister != ZERO_IDX);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[WriteRegister] = WriteData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass is suppressed during reset so reads see the cleared storage.
  always_comb begin
    bypass1 = RegWrite && !reset && (WriteRegister == ReadRegister1) &&
              (ReadRegister1 != ZERO_IDX);
    bypass2 = RegWrite && !reset && (WriteRegister == ReadRegister2) &&
              (ReadRegister2 != ZERO_IDX);

    if (ReadRegister1 == ZERO_IDX) begin
      ReadData1 = '0;
    end else if (bypass1) begin
      ReadData1 = WriteData;
    end else begin
      ReadData1 = regs_q[ReadRegister1];
    end

    if (ReadRegister2 == ZERO_IDX) begin
      ReadData2 = '0;
    end else if (bypass2) begin
      ReadData2 = WriteData;
    end else begin
      ReadData2 = regs_q[ReadRegister2];
    end
  end

endmodule
